serial_transmitter: RTL and testbench

SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

---
 rtl/serial_pkg.sv | 22 ++
 rtl/serial_tx_fifo.sv | 59 +++++
 rtl/serial_transmitter.sv | 146 ++++++++++++++
 tb/tb_serial_transmitter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared widths, frame length and FSM state encoding for
// the serial transmitter and the matching receiver.
package serial_pkg;

    localparam int DATA_W     = 7;
    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAD,
        PARITY,
        STOP
    } ser_state_t;

    // Even parity: XOR of the data bits.
    function automatic logic calc_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: synchronous character queue, count-based full/empty.
// Ports: clk, rst (sync, active high), push/push_data, pop/pop_data,
//        full, empty. Push when full and pop when empty are ignored.
module serial_tx_fifo
    import serial_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int            AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULLC = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign full     = (count == FULLC);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/serial_transmitter.sv
// serial_transmitter: 11-bit frame serializer (start, d0..d6, pad 0,
// even parity, stop), one bit per clk.
// Ports: clk, rst (sync, active high), in_data/in_valid/in_ready
//        handshake, serial_out (registered, idle 1), busy, frame_done.
// Build option SER_TX_FIFO_EN: FIFO_DEPTH-entry input queue; otherwise
// a single holding register buffers the next character.
module serial_transmitter
    import serial_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              frame_done
);

    ser_state_t        state_q;
    ser_state_t        state_d;
    logic [2:0]        bit_idx_q;
    logic [DATA_W-1:0] shreg_q;
    logic              par_q;
    logic              push;
    logic              avail;
    logic              load;
    logic [DATA_W-1:0] head_data;
    logic              line_d;
    logic              busy_d;
    logic              done_d;

    assign push = in_valid & in_ready;
    assign load = avail & ((state_q == IDLE) | (state_q == STOP));

`ifdef SER_TX_FIFO_EN
    logic q_full;
    logic q_empty;

    serial_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(in_data),
        .pop      (load),
        .pop_data (head_data),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Ready from occupancy only: no push-through when full.
    assign in_ready = ~q_full;
    assign avail    = ~q_empty;
`else
    logic              hold_v;
    logic [DATA_W-1:0] hold_q;
    logic              unused_depth;

    assign unused_depth = ^FIFO_DEPTH;
    assign in_ready     = ~hold_v;
    assign avail        = hold_v;
    assign head_data    = hold_q;

    // Push needs an empty register and pop a full one: never both.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v <= 1'b0;
            hold_q <= '0;
        end else if (push) begin
            hold_v <= 1'b1;
            hold_q <= in_data;
        end else if (load) begin
            hold_v <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (avail) state_d = START;
            START:   state_d = DATA;
            DATA:    if (bit_idx_q == 3'(DATA_W - 1)) state_d = PAD;
            PAD:     state_d = PARITY;
            PARITY:  state_d = STOP;
            STOP:    state_d = avail ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_idx_q <= '0;
            par_q     <= 1'b0;
        end else if (load) begin
            shreg_q   <= head_data;
            bit_idx_q <= '0;
            par_q     <= calc_parity(head_data);
        end else if (state_q == DATA) begin
            shreg_q   <= shreg_q >> 1;
            bit_idx_q <= (bit_idx_q == 3'(DATA_W - 1)) ? '0
                                                       : bit_idx_q + 1'b1;
        end
    end

    always_comb begin
        line_d = 1'b1;
        busy_d = (state_q != IDLE);
        done_d = (state_q == STOP);
        unique case (state_q)
            IDLE:    line_d = 1'b1;
            START:   line_d = 1'b0;
            DATA:    line_d = shreg_q[0];
            PAD:     line_d = 1'b0;
            PARITY:  line_d = par_q;
            STOP:    line_d = 1'b1;
            default: line_d = 1'b1;
        endcase
    end

    // Outputs are registered, so the line trails the state by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            serial_out <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            serial_out <= line_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// tb_serial_transmitter: constant frame table, directed corner cases and
// random traffic against a queue-based line model.
module tb_serial_transmitter;

`ifdef SER_TX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       serial_out;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    serial_transmitter #(
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .serial_out(serial_out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [6:0]  d;
        logic [10:0] frame;
    } vec_t;

    int         vectors = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [1:0] line_q[$];
    logic [6:0] char_q[$];
    logic [6:0] bq[$];
    logic       exp_so = 1'b1;
    logic       exp_busy = 1'b0;
    logic       exp_fd = 1'b0;
    logic       exp_rdy = 1'b1;

    function automatic logic [10:0] frame_of(input logic [6:0] d);
        return {1'b1, ^d, 1'b0, d, 1'b0};
    endfunction

    task automatic model_edge(input logic v, input logic [6:0] d,
                              input logic r);
        logic        acc;
        logic [1:0]  e;
        logic [6:0]  c;
        logic [10:0] f;
        acc = v && !r && (char_q.size() < CAP);
        if (r) begin
            line_q.delete();
            char_q.delete();
            exp_so = 1'b1;
            exp_busy = 1'b0;
            exp_fd = 1'b0;
        end else begin
            if (line_q.size() > 0) begin
                e = line_q.pop_front();
                exp_so = e[0];
                exp_busy = 1'b1;
                exp_fd = e[1];
            end else begin
                exp_so = 1'b1;
                exp_busy = 1'b0;
                exp_fd = 1'b0;
            end
            if (line_q.size() == 0 && char_q.size() > 0) begin
                c = char_q.pop_front();
                f = frame_of(c);
                for (int i = 0; i < 11; i++)
                    line_q.push_back({i == 10, f[i]});
            end
            if (acc)
                char_q.push_back(d);
        end
        exp_rdy = (char_q.size() < CAP);
    endtask

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d",
                     name, cyc, got, want);
        end
    endtask

    task automatic step(input logic v, input logic [6:0] d, input logic r);
        in_valid = v;
        in_data = d;
        rst = r;
        @(posedge clk);
        model_edge(v, d, r);
        @(negedge clk);
        cyc++;
        vectors++;
        if ({serial_out, busy, frame_done, in_ready} !==
            {exp_so, exp_busy, exp_fd, exp_rdy}) begin
            errors++;
            $display("FAIL model cyc=%0d so,busy,done,rdy got=%b%b%b%b want=%b%b%b%b",
                     cyc, serial_out, busy, frame_done, in_ready,
                     exp_so, exp_busy, exp_fd, exp_rdy);
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 80 && (line_q.size() > 0 || char_q.size() > 0); t++)
            step(1'b0, 7'h00, 1'b0);
        chk("idle_timeout", line_q.size() + char_q.size(), 0);
        step(1'b0, 7'h00, 1'b0);
    endtask

    task automatic burst();
        int idx;
        int busy_n;
        int done_n;
        int low_n;
        int n;
        logic acc;
        idx = 0;
        busy_n = 0;
        done_n = 0;
        low_n = 0;
        n = bq.size();
        for (int t = 0; t < 400 &&
             (idx < n || line_q.size() > 0 || char_q.size() > 0); t++) begin
            if (idx < n) begin
                acc = exp_rdy;
                step(1'b1, bq[idx], 1'b0);
                if (acc) idx++;
            end else begin
                step(1'b0, 7'h00, 1'b0);
            end
            if (busy) busy_n++;
            if (frame_done) done_n++;
            if (idx < n && !in_ready) low_n++;
        end
        chk("burst_sent", idx, n);
        chk("burst_busy", busy_n, 11 * n);
        chk("burst_done", done_n, n);
        chk("burst_rdy_low", int'(low_n > 0), 1);
    endtask

    initial begin
        vec_t tbl[6];
        int   bad;
        tbl[0] = '{d: 7'h55, frame: 11'b1_0_0_1010101_0};
        tbl[1] = '{d: 7'h01, frame: 11'b1_1_0_0000001_0};
        tbl[2] = '{d: 7'h7F, frame: 11'b1_1_0_1111111_0};
        tbl[3] = '{d: 7'h2A, frame: 11'b1_1_0_0101010_0};
        tbl[4] = '{d: 7'h15, frame: 11'b1_1_0_0010101_0};
        tbl[5] = '{d: 7'h00, frame: 11'b1_0_0_0000000_0};

        step(1'b0, 7'h00, 1'b1);
        step(1'b0, 7'h00, 1'b1);
        chk("rst_so", serial_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        step(1'b0, 7'h00, 1'b0);
        chk("rst_rdy", in_ready, 1);

        foreach (tbl[i]) begin
            wait_idle();
            chk("tbl_rdy", in_ready, 1);
            step(1'b1, tbl[i].d, 1'b0);
            step(1'b0, 7'h00, 1'b0);
            chk("tbl_lat_idle", serial_out, 1);
            for (int b = 0; b < 11; b++) begin
                step(1'b0, 7'h7F, 1'b0);
                chk("tbl_bit", serial_out, int'(tbl[i].frame[b]));
                chk("tbl_busy", busy, 1);
                chk("tbl_done", frame_done, int'(b == 10));
            end
            step(1'b0, 7'h00, 1'b0);
            chk("tbl_after_so", serial_out, 1);
            chk("tbl_after_busy", busy, 0);
        end

        // Abort a 7'h7F frame in its 4th bit with a second char queued.
        wait_idle();
        step(1'b1, 7'h7F, 1'b0);
        step(1'b0, 7'h00, 1'b0);
        step(1'b1, 7'h33, 1'b0);
        step(1'b0, 7'h00, 1'b0);
        step(1'b0, 7'h00, 1'b0);
        step(1'b0, 7'h00, 1'b0);
        step(1'b0, 7'h00, 1'b1);
        chk("abort_so", serial_out, 1);
        chk("abort_busy", busy, 0);
        chk("abort_rdy", in_ready, 1);
        bad = 0;
        for (int t = 0; t < 15; t++) begin
            step(1'b0, 7'h00, 1'b0);
            if (!serial_out || busy) bad++;
        end
        chk("abort_quiet", bad, 0);

        wait_idle();
        bq = '{7'h2A, 7'h15};
        burst();
        wait_idle();
        bq = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55};
        burst();
        wait_idle();

        for (int t = 0; t < 3000; t++) begin
            logic v;
            logic r;
            v = ((t / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                     : ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 499) == 0);
            step(v, 7'($urandom), r);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
